// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, word width and
// the {pc, instr} entry stored in the instruction buffer.
package fetch_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO. The head entry is visible on rdata_o
// whenever the FIFO is non-empty and reads as zero when empty, so consumers
// see clean outputs straight out of reset. clr_i empties it in one cycle and
// wins over a simultaneous push or pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)
                count_q <= count_q + 1'b1;
            else if (!do_push && do_pop)
                count_q <= count_q - 1'b1;
        end
    end

    // Entry storage; contents never need resetting because empty masks the output.
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage. Requests are issued at the current PC while the
// sum of outstanding requests and buffered instructions stays below DEPTH,
// which guarantees every returning response has a buffer slot. Responses
// come back in order without tags, so an address queue pairs each response
// with its PC. A flush empties both queues and, if requests are still in
// flight, enters DRAIN to swallow their stale responses.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            stall,
    input  logic            flush,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic            credit_ok;
    logic            fire;
    logic            rsp_accept;
    logic            consume;

    logic [XLEN-1:0] addr_head;
    logic            aq_full;
    logic            aq_empty;
    logic [CW-1:0]   aq_count;

    fetch_entry_t    buf_wdata;
    fetch_entry_t    buf_head;
    logic            buf_full;
    logic            buf_empty;
    logic [CW-1:0]   buf_count;

    assign credit_ok      = ({1'b0, outstanding_q} + {1'b0, buf_count}) < (CW + 1)'(DEPTH);
    assign imem_req_valid = !reset && (state_q == FETCH) && !flush && credit_ok;
    assign imem_req_addr  = pc;
    assign fire           = imem_req_valid && imem_req_ready;
    // The PC stage only advances on an accepted request.
    assign stall          = !fire;

    // Responses in DRAIN or coinciding with a flush belong to the old path.
    assign rsp_accept     = imem_rsp_valid && (state_q == FETCH) && !flush;

    assign buf_wdata.pc    = addr_head;
    assign buf_wdata.instr = imem_rsp_data;

    assign if_valid = !buf_empty;
    assign if_pc    = buf_head.pc;
    assign if_instr = buf_head.instr;
    assign consume  = if_valid && if_ready;

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (flush),
        .push_i  (fire),
        .wdata_i (pc),
        .pop_i   (rsp_accept),
        .rdata_o (addr_head),
        .full_o  (aq_full),
        .empty_o (aq_empty),
        .count_o (aq_count)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (flush),
        .push_i  (rsp_accept),
        .wdata_i (buf_wdata),
        .pop_i   (consume),
        .rdata_o (buf_head),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_count)
    );

    // Next-state for the in-flight counter, the drop counter and the FSM.
    always_comb begin
        outstanding_d = outstanding_q;
        if (fire && !imem_rsp_valid)
            outstanding_d = outstanding_q + 1'b1;
        else if (!fire && imem_rsp_valid && (outstanding_q != '0))
            outstanding_d = outstanding_q - 1'b1;

        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            FETCH: begin
                // Everything still in flight after this cycle must be discarded.
                if (flush) begin
                    drop_cnt_d = outstanding_d;
                    state_d    = (outstanding_d != '0) ? DRAIN : FETCH;
                end
            end
            DRAIN: begin
                // A flush here adds nothing: no requests were issued since the last one.
                if (imem_rsp_valid && (drop_cnt_q != '0))
                    drop_cnt_d = drop_cnt_q - 1'b1;
                state_d = (drop_cnt_d != '0) ? DRAIN : FETCH;
            end
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Invariants that the credit rule is supposed to make impossible to violate.
    always @(posedge clk) begin
        if (!reset) begin
            if (rsp_accept) assert (!buf_full);
            if (rsp_accept) assert (!aq_empty);
            if (fire)       assert (!aq_full);
            if (state_q == FETCH) assert (aq_count == outstanding_q);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch (DEPTH = 2). A bus model drives the PC stage and an
// in-order memory of configurable latency; every accepted request pushes the
// expected {pc, instr} into a scoreboard queue, and a monitor pops and compares
// each instruction decode consumes. Directed checks cover the scenario points.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        stall;
    logic        flush = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] flush_target = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t        pend[$];
    fetch_entry_t exp_q[$];

    instr_fetch #(.DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .stall          (stall),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready)
    );

    always #5 clk = ~clk;

    // Memory contents: the low half of the address tagged with 0xBEEF.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hBEEF, a[15:0]};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset two cycles, configure the environment, release into cycle 0.
    task automatic start_test(input int lat_v, input logic rdy_v, input logic ifr_v);
        reset = 1'b1;
        step(2);
        lat            = lat_v;
        imem_req_ready = rdy_v;
        if_ready       = ifr_v;
        reset          = 1'b0;
    endtask

    // Stop issuing, let everything drain, and require the scoreboard to be empty.
    task automatic finish_test(input string name);
        imem_req_ready = 1'b0;
        if_ready       = 1'b1;
        step(6);
        @(negedge clk);
        check32({name, "_sb_left"}, 32'(exp_q.size()), 32'd0);
        check1({name, "_idle_if_valid"}, if_valid, 1'b0);
        step(1);
    endtask

    // Wait (bounded) for the first valid instruction and check its contents.
    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (if_valid) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no if_valid within 20 cycles, required if_pc %08h", name, exp_pc);
        end else begin
            check32({name, "_pc"}, if_pc, exp_pc);
            check32({name, "_instr"}, if_instr, word(exp_pc));
        end
    endtask

    // PC stage and memory model: observe at negedge, drive just after posedge.
    initial begin : bfm
        logic [31:0]  nxt_pc;
        logic         fire;
        pend_t        p;
        fetch_entry_t e;
        nxt_pc = 32'h0;
        forever begin
            @(negedge clk);
            fire = imem_req_valid && imem_req_ready;
            if (reset) begin
                pend.delete();
                exp_q.delete();
                nxt_pc = 32'h0;
            end else begin
                if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
                if (flush) exp_q.delete();
                if (fire) begin
                    check32("req_addr", imem_req_addr, pc);
                    p.addr = imem_req_addr;
                    p.due  = cyc + lat;
                    pend.push_back(p);
                    e.pc    = pc;
                    e.instr = word(pc);
                    exp_q.push_back(e);
                end
                nxt_pc = flush ? flush_target : (fire ? pc + 32'd4 : pc);
            end
            @(posedge clk);
            #1;
            cyc++;
            pc = nxt_pc;
            if (reset || pend.size() == 0 || pend[0].due > cyc) begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end else begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = word(pend[0].addr);
            end
        end
    end

    // Monitor: every consumed instruction must match the scoreboard head.
    initial begin : monitor
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (!reset && !flush && if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got pc %08h instr %08h, required no instruction", if_pc, if_instr);
                end else begin
                    e = exp_q.pop_front();
                    $display("consume pc=%08h instr=%08h (expected pc=%08h instr=%08h)", if_pc, if_instr, e.pc, e.instr);
                    check32("sb_pc", if_pc, e.pc);
                    check32("sb_instr", if_instr, e.instr);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of test by 100000, required finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        step(2);
        @(negedge clk);
        check1("rst_if_valid", if_valid, 1'b0);
        check1("rst_req_valid", imem_req_valid, 1'b0);
        check1("rst_stall", stall, 1'b1);
        check32("rst_if_pc", if_pc, 32'h0);
        check32("rst_if_instr", if_instr, 32'h0);
        step(1);

        // Zero-wait memory streaming 0, 4, 8, ...
        start_test(1, 1'b1, 1'b1);
        @(negedge clk);
        check1("a_first_req", imem_req_valid, 1'b1);
        check1("a_first_stall", stall, 1'b0);
        step(1);
        @(negedge clk);
        check1("a_c1_if_valid", if_valid, 1'b0);
        step(1);
        @(negedge clk);
        check1("a_c2_if_valid", if_valid, 1'b1);
        check32("a_c2_if_pc", if_pc, 32'h0);
        step(10);
        finish_test("a");

        // Decode blocked: buffer fills with 0x0 and 0x4, fetch stalls.
        start_test(1, 1'b1, 1'b0);
        step(3);
        @(negedge clk);
        check1("b_stall", stall, 1'b1);
        check1("b_req_valid", imem_req_valid, 1'b0);
        check1("b_if_valid", if_valid, 1'b1);
        check32("b_head_pc", if_pc, 32'h0);
        check32("b_head_instr", if_instr, 32'hBEEF0000);
        check32("b_buf_count", 32'(dut.buf_count), 32'd2);
        step(1);
        if_ready = 1'b1;
        @(negedge clk);
        check32("b_c4_pc", if_pc, 32'h0);
        step(1);
        @(negedge clk);
        check1("b_c5_if_valid", if_valid, 1'b1);
        check32("b_c5_pc", if_pc, 32'h4);
        finish_test("b");

        // Latency 3, two in flight, flush to 0x100 before any response.
        start_test(3, 1'b1, 1'b1);
        step(2);
        flush_target = 32'h100;
        flush        = 1'b1;
        @(negedge clk);
        check1("c_flush_req_valid", imem_req_valid, 1'b0);
        step(1);
        flush = 1'b0;
        @(negedge clk);
        check1("c_c3_drain", dut.state_q == DRAIN, 1'b1);
        check1("c_c3_req_valid", imem_req_valid, 1'b0);
        check1("c_c3_if_valid", if_valid, 1'b0);
        step(1);
        @(negedge clk);
        check1("c_c4_drain", dut.state_q == DRAIN, 1'b1);
        check1("c_c4_req_valid", imem_req_valid, 1'b0);
        step(1);
        @(negedge clk);
        check1("c_c5_fetch", dut.state_q == FETCH, 1'b1);
        check1("c_c5_req_valid", imem_req_valid, 1'b1);
        check32("c_c5_req_addr", imem_req_addr, 32'h100);
        wait_valid("c_first", 32'h100);
        step(4);
        finish_test("c");

        // Flush in the same cycle as the first response (0x0) returns.
        start_test(3, 1'b1, 1'b1);
        step(3);
        flush_target = 32'h200;
        flush        = 1'b1;
        @(negedge clk);
        check1("d_flush_req_valid", imem_req_valid, 1'b0);
        step(1);
        flush = 1'b0;
        @(negedge clk);
        check1("d_after_if_valid", if_valid, 1'b0);
        check1("d_after_drain", dut.state_q == DRAIN, 1'b1);
        wait_valid("d_first", 32'h200);
        step(4);
        finish_test("d");

        // Reset asserted mid-cycle while instructions are in flight and buffered.
        start_test(2, 1'b1, 1'b0);
        step(3);
        @(negedge clk);
        check1("e_pre_if_valid", if_valid, 1'b1);
        check32("e_pre_if_instr", if_instr, 32'hBEEF0000);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check1("e_async_if_valid", if_valid, 1'b0);
        check32("e_async_if_instr", if_instr, 32'h0);
        check32("e_async_if_pc", if_pc, 32'h0);
        check1("e_async_req_valid", imem_req_valid, 1'b0);
        check1("e_async_stall", stall, 1'b1);
        start_test(1, 1'b1, 1'b1);
        wait_valid("e_restart", 32'h0);
        step(4);
        finish_test("e");

        // Memory not ready for five cycles: stall throughout, PC held.
        start_test(1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("f_stall", stall, 1'b1);
            check1("f_req_valid", imem_req_valid, 1'b1);
            check32("f_req_addr", imem_req_addr, 32'h0);
            step(1);
        end
        imem_req_ready = 1'b1;
        wait_valid("f_first", 32'h0);
        step(6);
        finish_test("f");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
